// File: rtl/sync_debounce.sv
// sync_debounce: per-channel synchroniser chain, debounce filter and
// registered rise/fall pulse generator for asynchronous board-level inputs.
module sync_debounce #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] D,
  input  logic             db_en,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] s [STAGES];

  logic [WIDTH-1:0] syn;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] z_nxt;

  assign syn = s[STAGES-1];

  // Synchroniser chain: plain flop-to-flop, no logic between stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        s[k] <= '0;
      end
    end else begin
      s[0] <= D;
      for (int unsigned k = 1; k < STAGES; k++) begin
        s[k] <= s[k-1];
      end
    end
  end

  // Debounce decision: count consecutive mismatches, accept on the last one.
  always_comb begin
    z_nxt = Z;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (!db_en) begin
        z_nxt[i] = syn[i];
      end else if (syn[i] != Z[i]) begin
        if (cnt[i] == CNT_LAST) begin
          z_nxt[i] = syn[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Level, counter and edge-pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Z    <= '0;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      Z    <= z_nxt;
      rise <= z_nxt & ~Z;
      fall <= ~z_nxt & Z;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default instance plus a
// WIDTH=1/STAGES=3/DB_CYCLES=1 instance sharing clock, reset and db_en.
module tb_sync_debounce;

  logic       clock;
  logic       reset_n;
  logic       db_en;
  logic [3:0] d;
  logic [3:0] z, rise, fall;
  logic [0:0] d1, z1, rise1, fall1;

  int checks   = 0;
  int failures = 0;

  sync_debounce u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .D       (d),
    .db_en   (db_en),
    .Z       (z),
    .rise    (rise),
    .fall    (fall)
  );

  sync_debounce #(.WIDTH(1), .STAGES(3), .DB_CYCLES(1)) u_p (
    .clock   (clock),
    .reset_n (reset_n),
    .D       (d1),
    .db_en   (db_en),
    .Z       (z1),
    .rise    (rise1),
    .fall    (fall1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int n,
                      input logic [3:0] ez, input logic [3:0] er, input logic [3:0] ef);
    chk($sformatf("%s_z n=%0d", tag, n), 32'(z), 32'(ez));
    chk($sformatf("%s_rise n=%0d", tag, n), 32'(rise), 32'(er));
    chk($sformatf("%s_fall n=%0d", tag, n), 32'(fall), 32'(ef));
  endtask

  task automatic chk1(input string tag, input int n,
                      input logic ez, input logic er, input logic ef);
    chk($sformatf("%s_z1 n=%0d", tag, n), 32'(z1), 32'(ez));
    chk($sformatf("%s_rise1 n=%0d", tag, n), 32'(rise1), 32'(er));
    chk($sformatf("%s_fall1 n=%0d", tag, n), 32'(fall1), 32'(ef));
  endtask

  initial begin
    logic [8:0] chat;
    chat = 9'b111101101;

    // Reset with all inputs high.
    reset_n = 1'b0;
    db_en   = 1'b1;
    d       = 4'hF;
    d1      = 1'b1;
    tick();
    tick();
    chk4("rst", 0, 4'h0, 4'h0, 4'h0);
    chk1("rst", 0, 1'b0, 1'b0, 1'b0);

    // Release: high inputs rise after the normal latency.
    reset_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk4("rel", n, (n >= 6) ? 4'hF : 4'h0, (n == 6) ? 4'hF : 4'h0, 4'h0);
      chk1("rel", n, n >= 4, n == 4, 1'b0);
    end

    // Asynchronous reset mid-cycle while rise is high.
    #3;
    reset_n = 1'b0;
    #1;
    chk4("async", 0, 4'h0, 4'h0, 4'h0);
    chk1("async", 0, 1'b0, 1'b0, 1'b0);
    d  = 4'h0;
    d1 = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk4("idle", 0, 4'h0, 4'h0, 4'h0);

    // Latency, rising: channel 0 and the parameter instance.
    d  = 4'b0001;
    d1 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk4("lat_up", n, {3'b000, n >= 6}, {3'b000, n == 6}, 4'h0);
      chk1("lat_up", n, n >= 4, n == 4, 1'b0);
    end

    // Latency, falling.
    d  = 4'b0000;
    d1 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk4("lat_dn", n, {3'b000, n < 6}, 4'h0, {3'b000, n == 6});
      chk1("lat_dn", n, n < 4, 1'b0, n == 4);
    end

    // 3-cycle glitch on channel 1 rejected; 1-cycle pulse accepted on u_p.
    d  = 4'b0010;
    d1 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk4("glitch3", n, 4'h0, 4'h0, 4'h0);
      chk1("pulse1", n, n == 4, n == 4, n == 5);
      if (n == 1) d1 = 1'b0;
      if (n == 3) d  = 4'b0000;
    end

    // 4-cycle pulse on channel 1 accepted for one debounce window.
    d = 4'b0010;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk4("glitch4", n, {2'b00, (n >= 6) && (n < 10), 1'b0},
           {2'b00, n == 6, 1'b0}, {2'b00, n == 10, 1'b0});
      if (n == 4) d = 4'b0000;
    end

    // Chatter on channel 2: 1,0,1,1,0,1,1,1,1 then held high.
    d[2] = chat[0];
    for (int n = 1; n <= 13; n++) begin
      tick();
      chk4("chatter", n, {1'b0, n >= 11, 2'b00}, {1'b0, n == 11, 2'b00}, 4'h0);
      d[2] = (n < 9) ? chat[n] : 1'b1;
    end

    // Bypass: channel 3 toggles every cycle, Z follows three edges later.
    db_en = 1'b0;
    d[3]  = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk4("bypass", n, {(n >= 3) && (n % 2 == 1), 3'b100},
           {(n >= 3) && (n % 2 == 1), 3'b000}, {(n >= 4) && (n % 2 == 0), 3'b000});
      d[3] = (n % 2 == 0);
    end

    // Debounce resumes mid-toggle; count starts from zero.
    db_en = 1'b1;
    for (int m = 1; m <= 12; m++) begin
      tick();
      chk4("resume", m, {m >= 10, 3'b100}, {m == 10, 3'b000}, 4'h0);
      d[3] = (m + 1 <= 4) ? ((m + 1) % 2 == 1) : 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
